// File: rtl/tc_fetch_unit.sv
// Instruction fetch: walks the PC over the program ROM and queues {pc, instr} pairs for the decoder.
// One word per cycle; head outputs are registered, so out_valid follows the PC by one cycle.
module tc_fetch_unit #(
  parameter int          BIT_WIDTH = 16,
  parameter int          DEPTH     = 2,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic                         redirect,
  input  logic [15:0]                  redirect_pc,
  output logic [15:0]                  rom_address,
  output logic                         rom_load,
  output logic                         rom_save,
  input  logic [BIT_WIDTH-1:0]         rom_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BIT_WIDTH-1:0]         out_instr,
  output logic [15:0]                  out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]          pc;
  logic [BIT_WIDTH-1:0] mem_instr [DEPTH];
  logic [15:0]          mem_pc    [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        rd_next;
  logic [CW-1:0]        count;
  logic [CW-1:0]        after_pop;
  logic                 pop;
  logic                 fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rom_address = pc;
  assign rom_load    = rst;
  assign rom_save    = 1'b0;
  assign fifo_count  = count;
  assign out_valid   = rst & (count != '0);

  assign pop       = out_valid & out_ready;
  // A same-cycle pop frees the slot, so a full FIFO being drained keeps fetching.
  assign fire      = rst & run & ~redirect & ((count < CW'(DEPTH)) | pop);
  assign rd_next   = pop ? ptr_inc(rd_ptr) : rd_ptr;
  assign after_pop = count - CW'(pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (redirect) begin
      pc     <= redirect_pc;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fire) begin
        pc     <= pc + 16'd1;
        wr_ptr <= ptr_inc(wr_ptr);
      end
      rd_ptr <= rd_next;
      count  <= count + CW'(fire) - CW'(pop);
      // Head register: bypass the incoming word when it lands in an otherwise empty queue.
      if (fire && after_pop == '0) begin
        out_instr <= rom_data;
        out_pc    <= pc;
      end else if (after_pop != '0) begin
        out_instr <= mem_instr[rd_next];
        out_pc    <= mem_pc[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      mem_instr[wr_ptr] <= rom_data;
      mem_pc[wr_ptr]    <= pc;
    end
  end

endmodule

// File: tb/tb_tc_fetch_unit.sv
// Bench for tc_fetch_unit: ROM returns 16'hA000 + address; a reference queue tracks expected FIFO contents.
module tb_tc_fetch_unit;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] rom_address;
  logic        rom_load;
  logic        rom_save;
  logic [15:0] rom_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [1:0]  fifo_count;

  logic        rst_w = 1'b0;
  logic        run_w = 1'b1;
  logic        redirect_w = 1'b0;
  logic [15:0] redirect_pc_w = 16'h0000;
  logic [15:0] rom_address_w;
  logic        rom_load_w;
  logic        rom_save_w;
  logic [15:0] rom_data_w;
  logic        out_valid_w;
  logic        out_ready_w = 1'b1;
  logic [15:0] out_instr_w;
  logic [15:0] out_pc_w;
  logic [1:0]  fifo_count_w;

  int passed = 0;
  int total  = 0;

  entry_t      sb[$];
  logic [15:0] m_pc = 16'h0000;

  always #5 clk = ~clk;

  assign rom_data   = 16'hA000 + rom_address;
  assign rom_data_w = 16'hA000 + rom_address_w;

  tc_fetch_unit #(.BIT_WIDTH(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .run(run), .redirect(redirect), .redirect_pc(redirect_pc),
    .rom_address(rom_address), .rom_load(rom_load), .rom_save(rom_save), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .fifo_count(fifo_count)
  );

  tc_fetch_unit #(.BIT_WIDTH(16), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .rst(rst_w), .run(run_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
    .rom_address(rom_address_w), .rom_load(rom_load_w), .rom_save(rom_save_w), .rom_data(rom_data_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_instr(out_instr_w), .out_pc(out_pc_w),
    .fifo_count(fifo_count_w)
  );

  function automatic logic [15:0] rom_of(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  // Advance one clock: update the reference queue from the inputs in force, then settle to the falling edge.
  task automatic tick();
    bit m_pop;
    bit m_fire;
    m_pop  = (sb.size() > 0) && out_ready;
    m_fire = rst && run && !redirect && ((sb.size() < DEPTH) || m_pop);
    @(posedge clk);
    if (!rst) begin
      sb.delete();
      m_pc = 16'h0000;
    end else if (redirect) begin
      sb.delete();
      m_pc = redirect_pc;
    end else begin
      if (m_pop) void'(sb.pop_front());
      if (m_fire) begin
        sb.push_back('{pc: m_pc, instr: rom_of(m_pc)});
        m_pc = m_pc + 16'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b1; out_ready = 1'b0; redirect = 1'b0;
    tick(); tick();
    total++; if (rom_address !== 16'h0000) $display("FAIL reset_rom_address got %h want 0000", rom_address); else passed++;
    total++; if (rom_load !== 1'b0) $display("FAIL reset_rom_load got %b want 0", rom_load); else passed++;
    total++; if (rom_save !== 1'b0) $display("FAIL reset_rom_save got %b want 0", rom_save); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if ({out_pc, out_instr} !== 32'h0) $display("FAIL reset_head got %h/%h want 0000/0000", out_pc, out_instr); else passed++;
    total++; if (fifo_count !== 2'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else passed++;
  endtask

  task automatic test_stream();
    rst = 1'b1; run = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({out_valid, out_pc, out_instr, rom_address} !== {1'b1, 16'(i), rom_of(16'(i)), 16'(i + 1)})
        $display("FAIL stream_%0d got v=%b pc=%h instr=%h addr=%h want v=1 pc=%h", i, out_valid, out_pc, out_instr, rom_address, 16'(i));
      else passed++;
      total++;
      if (rom_load !== 1'b1 || fifo_count !== 2'(sb.size()))
        $display("FAIL stream_count_%0d got load=%b count=%0d want load=1 count=%0d", i, rom_load, fifo_count, sb.size());
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_pc;
    rst = 1'b0; tick();
    rst = 1'b1; run = 1'b1; out_ready = 1'b0;
    tick(); tick(); tick();
    total++;
    if ({fifo_count, rom_address, out_pc, out_instr} !== {2'd2, 16'h0002, 16'h0000, 16'hA000})
      $display("FAIL bp_stall got count=%0d addr=%h pc=%h instr=%h want 2/0002/0000/A000", fifo_count, rom_address, out_pc, out_instr);
    else passed++;
    out_ready = 1'b1;
    exp_pc = 16'h0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, exp_pc, rom_of(exp_pc)})
        $display("FAIL bp_drain_%0d got v=%b pc=%h instr=%h want v=1 pc=%h", i, out_valid, out_pc, out_instr, exp_pc);
      else passed++;
      total++;
      if (sb.size() == 0 || {out_pc, out_instr, fifo_count} !== {sb[0].pc, sb[0].instr, 2'(sb.size())})
        $display("FAIL bp_sb_%0d got pc=%h count=%0d want queue size %0d", i, out_pc, fifo_count, sb.size());
      else passed++;
      exp_pc = exp_pc + 16'd1;
    end
  endtask

  task automatic test_redirect();
    logic [15:0] held;
    out_ready = 1'b0; run = 1'b1;
    tick();
    held = out_pc;
    tick();
    total++;
    if (fifo_count !== 2'd2 || out_pc !== held)
      $display("FAIL redir_full got count=%0d pc=%h want 2/%h", fifo_count, out_pc, held);
    else passed++;
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    total++;
    if ({fifo_count, out_valid, rom_address} !== {2'd0, 1'b0, 16'h0040})
      $display("FAIL redir_flush got count=%0d v=%b addr=%h want 0/0/0040", fifo_count, out_valid, rom_address);
    else passed++;
    tick();
    total++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 16'h0040, 16'hA040})
      $display("FAIL redir_first got v=%b pc=%h instr=%h want 1/0040/A040", out_valid, out_pc, out_instr);
    else passed++;
    run = 1'b0; redirect = 1'b1; redirect_pc = 16'h0080;
    tick();
    redirect = 1'b0;
    tick();
    total++;
    if ({rom_address, out_valid, fifo_count} !== {16'h0080, 1'b0, 2'd0})
      $display("FAIL redir_halted got addr=%h v=%b count=%0d want 0080/0/0", rom_address, out_valid, fifo_count);
    else passed++;
    run = 1'b1;
    tick();
    total++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 16'h0080, 16'hA080})
      $display("FAIL redir_resume got v=%b pc=%h instr=%h want 1/0080/A080", out_valid, out_pc, out_instr);
    else passed++;
  endtask

  task automatic test_run_toggle();
    logic [7:0] pattern;
    int runs;
    bit prev_run;
    pattern = 8'b1101_1001;
    rst = 1'b0; tick();
    rst = 1'b1; out_ready = 1'b1;
    runs = 0;
    for (int i = 0; i < 8; i++) begin
      run = pattern[i];
      prev_run = pattern[i];
      tick();
      if (prev_run) runs++;
      total++;
      if ({rom_address, out_valid} !== {16'(runs), prev_run} || fifo_count > 2'(DEPTH))
        $display("FAIL run_%0d got addr=%h v=%b count=%0d want addr=%h v=%b", i, rom_address, out_valid, fifo_count, 16'(runs), prev_run);
      else passed++;
      if (sb.size() != 0) begin
        total++;
        if ({out_pc, out_instr} !== {sb[0].pc, sb[0].instr})
          $display("FAIL run_head_%0d got pc=%h instr=%h want %h/%h", i, out_pc, out_instr, sb[0].pc, sb[0].instr);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1; run = 1'b1; out_ready = 1'b0; redirect = 1'b0;
    tick(); tick(); tick();
    total++;
    if (fifo_count !== 2'd2) $display("FAIL mid_full got count=%0d want 2", fifo_count); else passed++;
    rst = 1'b0; redirect = 1'b1; redirect_pc = 16'h0055;
    tick();
    total++;
    if ({out_valid, fifo_count, rom_load, rom_address} !== {1'b0, 2'd0, 1'b0, 16'h0000})
      $display("FAIL mid_reset got v=%b count=%0d load=%b addr=%h want 0/0/0/0000", out_valid, fifo_count, rom_load, rom_address);
    else passed++;
    total++;
    if ({out_pc, out_instr} !== 32'h0) $display("FAIL mid_reset_head got %h/%h want 0000/0000", out_pc, out_instr); else passed++;
    rst = 1'b1; redirect = 1'b0; out_ready = 1'b1;
    tick();
    total++;
    if ({out_valid, out_pc, out_instr, rom_address, rom_load} !== {1'b1, 16'h0000, 16'hA000, 16'h0001, 1'b1})
      $display("FAIL mid_resume got v=%b pc=%h instr=%h addr=%h load=%b want 1/0000/A000/0001/1", out_valid, out_pc, out_instr, rom_address, rom_load);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc;
    run = 1'b0;
    total++;
    if ({out_valid_w, rom_address_w, rom_load_w} !== {1'b0, 16'hFFFE, 1'b0})
      $display("FAIL wrap_reset got v=%b addr=%h load=%b want 0/FFFE/0", out_valid_w, rom_address_w, rom_load_w);
    else passed++;
    rst_w = 1'b1;
    exp_pc = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({out_valid_w, out_pc_w, out_instr_w, rom_address_w} !== {1'b1, exp_pc, rom_of(exp_pc), exp_pc + 16'd1})
        $display("FAIL wrap_%0d got v=%b pc=%h instr=%h addr=%h want pc=%h", i, out_valid_w, out_pc_w, out_instr_w, rom_address_w, exp_pc);
      else passed++;
      exp_pc = exp_pc + 16'd1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_run_toggle();
    test_reset_midstream();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
